// File: rtl/row_fetcher.sv
// rtl/row_fetcher.sv - fetches one board row from RAM into a shadow buffer, then swaps it onto Row
// Row only changes on the SWAP edge; requests arriving while busy are kept in a 1-deep newest-wins slot.
module row_fetcher #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  LD_Row,
    input  logic [7:0]            rowNum,
    output logic [7:0]            mem_addr,
    output logic                  mem_re,
    input  logic [15:0]           mem_rdata,
    output logic [COLS-1:0][15:0] Row,
    output logic                  rowReady,
    output logic                  busy
);

    localparam int         CW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [8:0] ROWS_LIM = 9'(ROWS);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, SWAP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [7:0]             target_q, target_d;
    logic                   oor_q, oor_d;
    logic                   pend_q, pend_d;
    logic [7:0]             pend_row_q, pend_row_d;
    logic                   ld_prev_q;
    logic [COLS-1:0][15:0]  shadow_q, shadow_d;
    logic [COLS-1:0][15:0]  row_q, row_d;
    logic                   ready_q, ready_d;

    logic                   req;
    logic [7:0]             start_row;

    assign req = LD_Row & ~ld_prev_q;

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            target_q   <= '0;
            oor_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_row_q <= '0;
            ld_prev_q  <= 1'b0;
            shadow_q   <= '0;
            row_q      <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            target_q   <= target_d;
            oor_q      <= oor_d;
            pend_q     <= pend_d;
            pend_row_q <= pend_row_d;
            ld_prev_q  <= LD_Row;
            shadow_q   <= shadow_d;
            row_q      <= row_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        target_d   = target_q;
        oor_d      = oor_q;
        pend_d     = pend_q;
        pend_row_d = pend_row_q;
        shadow_d   = shadow_q;
        row_d      = row_q;
        ready_d    = 1'b0;
        start_row  = '0;

        // Any edge outside IDLE (including on the SWAP edge) lands in the pending slot.
        if (req && (state_q != IDLE)) begin
            pend_d     = 1'b1;
            pend_row_d = rowNum;
        end

        case (state_q)
            IDLE: begin
                if (req || pend_q) begin
                    start_row = req ? rowNum : pend_row_q;
                    pend_d    = 1'b0;
                    target_d  = start_row;
                    col_d     = '0;
                    oor_d     = ({1'b0, start_row} >= ROWS_LIM);
                    state_d   = oor_d ? DRAIN : READ;
                end
            end
            READ: begin
                // Read data trails the address by one cycle, so it lands in cell col-1.
                if (col_q != '0) begin
                    shadow_d[col_q - 1'b1] = mem_rdata;
                end
                if (col_q == CW'(COLS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DRAIN: begin
                if (oor_q) begin
                    shadow_d = '0;
                end else begin
                    shadow_d[COLS-1] = mem_rdata;
                end
                state_d = SWAP;
            end
            SWAP: begin
                row_d   = shadow_q;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        mem_re   = (state_q == READ);
        mem_addr = '0;
        if (state_q == READ) begin
            mem_addr = target_q * 8'(COLS) + 8'(col_q);
        end
    end

    assign Row      = row_q;
    assign rowReady = ready_q;

endmodule

// File: tb/tb_row_fetcher.sv
// tb/tb_row_fetcher.sv - randomized bench for row_fetcher against a RAM model and a row-level reference
module tb_row_fetcher;

    localparam int COLS = 10;
    localparam int ROWS = 20;

    logic                  Clk = 1'b0;
    logic                  reset;
    logic                  LD_Row;
    logic [7:0]            rowNum;
    logic [7:0]            mem_addr;
    logic                  mem_re;
    logic [15:0]           mem_rdata;
    logic [COLS-1:0][15:0] Row;
    logic                  rowReady;
    logic                  busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0]           ram [0:255];
    logic [COLS-1:0][15:0] disp_row;

    int         re_count    = 0;
    int         ready_count = 0;
    logic [7:0] addr_log [$];

    row_fetcher #(.COLS(COLS), .ROWS(ROWS)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .LD_Row    (LD_Row),
        .rowNum    (rowNum),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .Row       (Row),
        .rowReady  (rowReady),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    always @(negedge Clk) begin
        if (mem_re) begin
            re_count++;
            addr_log.push_back(mem_addr);
        end
        if (rowReady) ready_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [COLS-1:0][15:0] model_row(input int r);
        logic [COLS-1:0][15:0] v;
        v = '0;
        if (r < ROWS) begin
            for (int k = 0; k < COLS; k++) v[k] = ram[r*COLS + k];
        end
        return v;
    endfunction

    task automatic fill_ram_random();
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    endtask

    // Called at a negedge with the DUT idle and LD_Row low; checks every cycle until the swap.
    task automatic fetch_row(input int r, input string tag);
        logic [COLS-1:0][15:0] exp_new;
        int   lat;
        logic exp_re;
        logic [7:0] exp_addr;
        exp_new = model_row(r);
        lat     = (r < ROWS) ? COLS + 2 : 2;
        LD_Row  = 1'b1;
        rowNum  = 8'(r);
        @(negedge Clk);
        LD_Row  = 1'b0;
        for (int n = 0; n <= lat; n++) begin
            exp_re   = (r < ROWS) && (n < COLS);
            exp_addr = exp_re ? 8'(r*COLS + n) : 8'd0;
            vectors++;
            if (mem_re !== exp_re) begin
                miscompares++;
                $display("FAIL %s mem_re row=%0d n=%0d: got %b exp %b", tag, r, n, mem_re, exp_re);
            end
            vectors++;
            if (mem_addr !== exp_addr) begin
                miscompares++;
                $display("FAIL %s mem_addr row=%0d n=%0d: got %0d exp %0d", tag, r, n, mem_addr, exp_addr);
            end
            vectors++;
            if (busy !== (n < lat)) begin
                miscompares++;
                $display("FAIL %s busy row=%0d n=%0d: got %b exp %b", tag, r, n, busy, (n < lat));
            end
            vectors++;
            if (rowReady !== (n == lat)) begin
                miscompares++;
                $display("FAIL %s rowReady row=%0d n=%0d: got %b exp %b", tag, r, n, rowReady, (n == lat));
            end
            vectors++;
            if (Row !== ((n < lat) ? disp_row : exp_new)) begin
                miscompares++;
                $display("FAIL %s Row row=%0d n=%0d: got %h exp %h", tag, r, n, Row,
                         ((n < lat) ? disp_row : exp_new));
            end
            if (n < lat) @(negedge Clk);
        end
        disp_row = exp_new;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        LD_Row = 1'b0;
        rowNum = 8'd0;
        fill_ram_random();
        repeat (3) @(negedge Clk);
        vectors++;
        if (Row !== '0) begin
            miscompares++;
            $display("FAIL reset Row: got %h exp 0", Row);
        end
        vectors++;
        if (rowReady !== 1'b0 || busy !== 1'b0 || mem_re !== 1'b0) begin
            miscompares++;
            $display("FAIL reset flags: got rdy=%b busy=%b re=%b exp 0 0 0", rowReady, busy, mem_re);
        end
        vectors++;
        if (mem_addr !== 8'd0) begin
            miscompares++;
            $display("FAIL reset mem_addr: got %0d exp 0", mem_addr);
        end
        reset = 1'b1;
        @(negedge Clk);
        disp_row = '0;
    endtask

    task automatic test_basic();
        logic [15:0] exp_word;
        fill_ram_random();
        for (int k = 0; k < COLS; k++) ram[30 + k] = 16'h0100 + 16'(k);
        fetch_row(3, "basic");
        for (int k = 0; k < COLS; k++) begin
            exp_word = 16'h0100 + 16'(k);
            vectors++;
            if (Row[k] !== exp_word) begin
                miscompares++;
                $display("FAIL basic cell %0d: got %h exp %h", k, Row[k], exp_word);
            end
        end
    endtask

    task automatic test_random_rows();
        fill_ram_random();
        fetch_row(ROWS - 1, "last_row");
        fetch_row(0, "first_row");
        repeat (6) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            fetch_row($urandom_range(0, ROWS - 1), "random");
        end
    endtask

    task automatic test_out_of_range();
        fetch_row(25, "oor25");
        fetch_row(ROWS - 2, "after_oor");
        fetch_row(ROWS, "oor_edge");
        fetch_row($urandom_range(ROWS, 255), "oor_rand");
    endtask

    task automatic test_held();
        int base_re, base_rdy;
        fill_ram_random();
        #1;
        base_re  = re_count;
        base_rdy = ready_count;
        LD_Row = 1'b1;
        rowNum = 8'd5;
        repeat (50) @(negedge Clk);
        LD_Row = 1'b0;
        repeat (5) @(negedge Clk);
        #1;
        vectors++;
        if (re_count - base_re !== 10) begin
            miscompares++;
            $display("FAIL held re_cycles: got %0d exp 10", re_count - base_re);
        end
        vectors++;
        if (ready_count - base_rdy !== 1) begin
            miscompares++;
            $display("FAIL held ready_pulses: got %0d exp 1", ready_count - base_rdy);
        end
        vectors++;
        if (Row !== model_row(5)) begin
            miscompares++;
            $display("FAIL held Row: got %h exp %h", Row, model_row(5));
        end
        disp_row = model_row(5);
    endtask

    task automatic test_pending();
        int base_idx, base_rdy;
        logic [7:0] exp_addr;
        fill_ram_random();
        #1;
        base_idx = addr_log.size();
        base_rdy = ready_count;
        LD_Row = 1'b1; rowNum = 8'd2;
        @(negedge Clk); LD_Row = 1'b0;
        @(negedge Clk);
        @(negedge Clk); LD_Row = 1'b1; rowNum = 8'd7;
        @(negedge Clk); LD_Row = 1'b0;
        @(negedge Clk); LD_Row = 1'b1; rowNum = 8'd9;
        @(negedge Clk); LD_Row = 1'b0;
        repeat (35) @(negedge Clk);
        #1;
        vectors++;
        if (addr_log.size() - base_idx !== 20) begin
            miscompares++;
            $display("FAIL pending read_count: got %0d exp 20", addr_log.size() - base_idx);
        end else begin
            for (int i = 0; i < 20; i++) begin
                exp_addr = (i < 10) ? 8'(20 + i) : 8'(90 + i - 10);
                vectors++;
                if (addr_log[base_idx + i] !== exp_addr) begin
                    miscompares++;
                    $display("FAIL pending addr[%0d]: got %0d exp %0d", i, addr_log[base_idx + i], exp_addr);
                end
            end
        end
        vectors++;
        if (ready_count - base_rdy !== 2) begin
            miscompares++;
            $display("FAIL pending ready_pulses: got %0d exp 2", ready_count - base_rdy);
        end
        vectors++;
        if (Row !== model_row(9)) begin
            miscompares++;
            $display("FAIL pending Row: got %h exp %h", Row, model_row(9));
        end
        disp_row = model_row(9);
    endtask

    task automatic test_swap_edge();
        int a, b, base_idx, base_rdy;
        logic [7:0] exp_addr;
        fill_ram_random();
        a = $urandom_range(0, ROWS - 1);
        b = (a + 1 + $urandom_range(0, ROWS - 2)) % ROWS;
        #1;
        base_idx = addr_log.size();
        base_rdy = ready_count;
        LD_Row = 1'b1; rowNum = 8'(a);
        @(negedge Clk); LD_Row = 1'b0;
        repeat (11) @(negedge Clk);
        LD_Row = 1'b1; rowNum = 8'(b);
        @(negedge Clk); LD_Row = 1'b0;
        vectors++;
        if (rowReady !== 1'b1 || Row !== model_row(a)) begin
            miscompares++;
            $display("FAIL swap_edge first_swap: got rdy=%b Row=%h exp rdy=1 Row=%h", rowReady, Row, model_row(a));
        end
        repeat (20) @(negedge Clk);
        #1;
        vectors++;
        if (addr_log.size() - base_idx !== 20) begin
            miscompares++;
            $display("FAIL swap_edge read_count: got %0d exp 20", addr_log.size() - base_idx);
        end else begin
            for (int i = 0; i < 20; i++) begin
                exp_addr = (i < 10) ? 8'(a*COLS + i) : 8'(b*COLS + i - 10);
                vectors++;
                if (addr_log[base_idx + i] !== exp_addr) begin
                    miscompares++;
                    $display("FAIL swap_edge addr[%0d]: got %0d exp %0d", i, addr_log[base_idx + i], exp_addr);
                end
            end
        end
        vectors++;
        if (ready_count - base_rdy !== 2 || Row !== model_row(b)) begin
            miscompares++;
            $display("FAIL swap_edge final: got pulses=%0d Row=%h exp pulses=2 Row=%h",
                     ready_count - base_rdy, Row, model_row(b));
        end
        disp_row = model_row(b);
    endtask

    task automatic test_reset_abort();
        int base_rdy;
        fill_ram_random();
        #1;
        base_rdy = ready_count;
        LD_Row = 1'b1; rowNum = 8'd4;
        @(negedge Clk); LD_Row = 1'b0;
        repeat (4) @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        vectors++;
        if (Row !== '0 || busy !== 1'b0 || mem_re !== 1'b0 || rowReady !== 1'b0 || mem_addr !== 8'd0) begin
            miscompares++;
            $display("FAIL abort state: got Row=%h busy=%b re=%b rdy=%b addr=%0d exp all 0",
                     Row, busy, mem_re, rowReady, mem_addr);
        end
        LD_Row = 1'b1; rowNum = 8'd6;
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        vectors++;
        if (mem_re !== 1'b1 || mem_addr !== 8'd60 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort held_release: got re=%b addr=%0d busy=%b exp 1 60 1", mem_re, mem_addr, busy);
        end
        LD_Row = 1'b0;
        repeat (15) @(negedge Clk);
        #1;
        vectors++;
        if (ready_count - base_rdy !== 1) begin
            miscompares++;
            $display("FAIL abort ready_pulses: got %0d exp 1", ready_count - base_rdy);
        end
        vectors++;
        if (Row !== model_row(6)) begin
            miscompares++;
            $display("FAIL abort Row: got %h exp %h", Row, model_row(6));
        end
        disp_row = model_row(6);
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_rows();
        test_out_of_range();
        test_held();
        test_pending();
        test_swap_edge();
        test_reset_abort();
        fetch_row($urandom_range(0, ROWS - 1), "post_abort");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
